// File: rtl/conv_pkg.sv
// Shared width constants for the byte-serial <-> parallel word converters.
package conv_pkg;
    localparam int BYTE_W    = 8;
    localparam int NUM_BYTES = 9;
    localparam int WORD_W    = BYTE_W * NUM_BYTES;
    localparam int CNT_W     = $clog2(NUM_BYTES);
endpackage

// File: rtl/conv_parallel_to_seq.sv
// Parallel word to byte-serial converter, LSB byte first, with one pending word so
// back-to-back words stream at one byte per cycle.
module conv_parallel_to_seq #(
    parameter int BYTE_W    = conv_pkg::BYTE_W,
    parameter int NUM_BYTES = conv_pkg::NUM_BYTES
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [BYTE_W*NUM_BYTES-1:0] data_in,
    input  logic                        valid_in,
    input  logic                        sof_in,
    output logic                        busy_out,
    output logic [BYTE_W-1:0]           data_out,
    output logic                        valid_out,
    output logic                        sof_out,
    input  logic                        busy_in
);
    localparam int WORD_W = BYTE_W * NUM_BYTES;
    localparam int CNT_W  = $clog2(NUM_BYTES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

    logic [WORD_W-1:0] r_sh;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_sh_valid;
    logic              r_sh_sof;
    logic [WORD_W-1:0] r_pend;
    logic              r_pend_valid;
    logic              r_pend_sof;

    logic w_accept;
    logic w_consume;
    logic w_sh_free;

    assign w_accept  = valid_in && !r_pend_valid;
    assign w_consume = r_sh_valid && !busy_in;
    // The shifter can take a new word in the same cycle its last byte leaves.
    assign w_sh_free = !r_sh_valid || (w_consume && (r_cnt == LAST_CNT));

    assign busy_out  = r_pend_valid;
    assign data_out  = r_sh[BYTE_W-1:0];
    assign valid_out = r_sh_valid;
    assign sof_out   = r_sh_valid && r_sh_sof && (r_cnt == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sh         <= '0;
            r_cnt        <= '0;
            r_sh_valid   <= 1'b0;
            r_sh_sof     <= 1'b0;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_pend_sof   <= 1'b0;
        end else if (w_sh_free) begin
            if (r_pend_valid) begin
                r_sh         <= r_pend;
                r_sh_sof     <= r_pend_sof;
                r_cnt        <= '0;
                r_sh_valid   <= 1'b1;
                r_pend_valid <= w_accept;
                if (w_accept) begin
                    r_pend     <= data_in;
                    r_pend_sof <= sof_in;
                end
            end else if (w_accept) begin
                r_sh       <= data_in;
                r_sh_sof   <= sof_in;
                r_cnt      <= '0;
                r_sh_valid <= 1'b1;
            end else begin
                r_sh_valid <= 1'b0;
            end
        end else begin
            if (w_consume) begin
                r_sh  <= r_sh >> BYTE_W;
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_accept) begin
                r_pend       <= data_in;
                r_pend_sof   <= sof_in;
                r_pend_valid <= 1'b1;
            end
        end
    end
endmodule
